// File: rtl/alu_param_pkg.sv
// alu_param_pkg: opcode constants and controller state type shared by the ALU slice
package alu_param_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    typedef enum logic [1:0] {IDLE, MUL, HOLD} stateT;
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add multiplier, one multiplier bit per cycle, done on the last bit
module alu_iter_mul #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && cnt == CW'(WIDTH - 1);
    // load operands on start, then fold in one partial product per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= !done;
        end
    end
endmodule

// File: rtl/alu_param_hs.sv
// alu_param_hs: handshaked ALU with registered result/flags; MUL only when ALU_PARAM_HS_MUL_EN is defined
module alu_param_hs
    import alu_param_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);
    stateT            state;
    logic             accept;
    logic             isSub;
    logic             isArith;
    logic             isMul;
    logic             isLegal;
    logic [WIDTH-1:0] bOp;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nextResult;
    logic             nextCarry;
    logic             nextOvf;
    assign in_ready  = !rst && (state == IDLE || (state == HOLD && out_ready));
    assign out_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    assign isSub     = alu_op == OP_SUB;
    assign isArith   = alu_op == OP_ADD || isSub;
    assign bOp       = isSub ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, bOp} + {{WIDTH{1'b0}}, isSub | carry_in};
`ifdef ALU_PARAM_HS_MUL_EN
    logic                 mulDone;
    logic [2*WIDTH-1:0]   mulProduct;
    assign isMul = alu_op == OP_MUL;
    alu_iter_mul #(.WIDTH(WIDTH)) mulUnit (
        .clk(clk),
        .rst(rst),
        .start(accept && isMul),
        .a(a),
        .b(b),
        .done(mulDone),
        .product(mulProduct)
    );
`else
    assign isMul = 1'b0;
`endif
    // single-cycle ops; anything unrecognised falls through to zero
    always_comb begin
        isLegal    = isMul || alu_op == OP_AND || alu_op == OP_OR || isArith || alu_op == OP_SLT || alu_op == OP_NOR;
        nextResult = alu_op == OP_AND ? a & b :
                     alu_op == OP_OR  ? a | b :
                     isArith          ? sum[WIDTH-1:0] :
                     alu_op == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
                     alu_op == OP_NOR ? ~(a | b) : '0;
        nextCarry  = isArith && sum[WIDTH];
        nextOvf    = isArith && a[WIDTH-1] == bOp[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
    end
    // controller: accept into HOLD or MUL, hold until consumed, return to IDLE when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && isMul) begin
            state <= MUL;
        end else if (accept) begin
            state     <= HOLD;
            result    <= nextResult;
            carry_out <= nextCarry;
            overflow  <= nextOvf;
            zero      <= nextResult == '0;
            illegal   <= !isLegal;
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
`ifdef ALU_PARAM_HS_MUL_EN
        end else if (state == MUL && mulDone) begin
            state     <= HOLD;
            result    <= mulProduct[WIDTH-1:0];
            carry_out <= 1'b0;
            overflow  <= |mulProduct[2*WIDTH-1:WIDTH];
            zero      <= mulProduct[WIDTH-1:0] == '0;
            illegal   <= 1'b0;
`endif
        end
    end
endmodule
